// File: rtl/pool_arbiter.sv
// Round-robin arbiter sharing one avg_pool_unit among 4 window requesters.
// Latency: gnt at T, rsp_valid at T+5+LATENCY; result held until rsp_ready, no grants meanwhile.
module pool_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*128-1:0]   win_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [31:0]              pool_ip,
    output logic                     pool_en,
    output logic                     pool_rst,
    input  logic [31:0]              pool_op,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [31:0]              rsp_data,
    input  logic                     rsp_ready
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         feed_cnt_q, feed_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         id_q, id_d;
    logic [127:0]       win_q, win_d;

    logic [NUM_REQ-1:0] gnt_d;
    logic               busy_d;
    logic [31:0]        pool_ip_d;
    logic               pool_en_d;
    logic               pool_rst_d;
    logic               rsp_valid_d;
    logic [1:0]         rsp_id_d;
    logic [31:0]        rsp_data_d;

    logic               found;
    logic [1:0]         sel;
    logic [1:0]         idx;

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        state_d     = state_q;
        feed_cnt_d  = feed_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        win_d       = win_q;
        gnt_d       = '0;
        pool_ip_d   = '0;
        pool_en_d   = 1'b0;
        pool_rst_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        found       = 1'b0;
        sel         = rr_ptr_q;
        idx         = '0;

        case (state_q)
            IDLE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = rr_ptr_q + 2'(k);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                if (found) begin
                    state_d    = CLEAR;
                    id_d       = sel;
                    win_d      = win_data[{sel, 7'd0} +: 128];
                    gnt_d[sel] = 1'b1;
                    pool_rst_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d    = FEED;
                feed_cnt_d = 2'd0;
                pool_en_d  = 1'b1;
                pool_ip_d  = win_q[31:0];
            end
            FEED: begin
                if (feed_cnt_q == 2'd3) begin
                    state_d   = WAIT;
                    lat_cnt_d = '0;
                end else begin
                    feed_cnt_d = feed_cnt_q + 2'd1;
                    pool_en_d  = 1'b1;
                    pool_ip_d  = win_q[{feed_cnt_d, 5'd0} +: 32];
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAT_W'(LATENCY - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = pool_op;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = id_q + 2'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            feed_cnt_q <= '0;
            lat_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            win_q      <= '0;
            gnt        <= '0;
            busy       <= 1'b0;
            pool_ip    <= '0;
            pool_en    <= 1'b0;
            pool_rst   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            win_q      <= win_d;
            gnt        <= gnt_d;
            busy       <= busy_d;
            pool_ip    <= pool_ip_d;
            pool_en    <= pool_en_d;
            pool_rst   <= pool_rst_d;
            rsp_valid  <= rsp_valid_d;
            rsp_id     <= rsp_id_d;
            rsp_data   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_pool_arbiter.sv
// Directed bench for pool_arbiter with a behavioural avg_pool_unit (sum >>> 2).
module tb_pool_arbiter;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [511:0]       win_data;
    logic [3:0]         gnt;
    logic               busy;
    logic signed [31:0] pool_ip;
    logic               pool_en;
    logic               pool_rst;
    logic signed [31:0] pool_op;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    pool_arbiter #(.NUM_REQ(4), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .req(req), .win_data(win_data),
        .gnt(gnt), .busy(busy), .pool_ip(pool_ip), .pool_en(pool_en),
        .pool_rst(pool_rst), .pool_op(pool_op), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Averaging unit: accumulate while enabled, result valid well within LATENCY cycles.
    logic signed [31:0] acc;
    always @(posedge clk or posedge rst) begin
        if (rst)           acc <= '0;
        else if (pool_rst) acc <= '0;
        else if (pool_en)  acc <= acc + pool_ip;
    end
    assign pool_op = acc >>> 2;

    function automatic logic [127:0] win4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (gnt != 4'b0000) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick();
        n_cmp++;
        if ({gnt, busy, pool_ip, pool_en, pool_rst, rsp_valid, rsp_id, rsp_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%b busy=%b ip=%0d en=%b prst=%b vld=%b id=%0d data=%h, want all 0",
                     gnt, busy, pool_ip, pool_en, pool_rst, rsp_valid, rsp_id, rsp_data);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: gnt=%b busy=%b, want 0000 0", gnt, busy);
        end
    endtask

    task automatic test_single();
        int exp_ip;
        win_data       = '0;
        win_data[127:0] = win4(10, 20, 30, 40);
        rsp_ready      = 1'b1;
        req            = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || pool_rst !== 1'b1 || pool_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b busy=%b prst=%b en=%b, want 0001 1 1 0", gnt, busy, pool_rst, pool_en);
        end
        req = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_ip = 10 * k;
            n_cmp++;
            if (pool_ip !== exp_ip || pool_en !== 1'b1 || pool_rst !== 1'b0 || gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL single_feed%0d: ip=%0d en=%b prst=%b gnt=%b, want %0d 1 0 0000",
                         k, pool_ip, pool_en, pool_rst, gnt, exp_ip);
            end
        end
        for (int k = 5; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b0 || pool_en !== 1'b0 || pool_ip !== 0) begin
                n_err++;
                $display("FAIL single_wait_T+%0d: vld=%b en=%b ip=%0d, want 0 0 0", k, rsp_valid, pool_en, pool_ip);
            end
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd25) begin
            n_err++;
            $display("FAIL single_rsp_T+9: vld=%b id=%0d data=%0d, want 1 0 25", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_after_hs: vld=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) win_data[i*128 +: 128] = win4(4*i+4, 4*i+4, 4*i+4, 4*i+4);
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(ok);
            n_cmp++;
            if (!ok || gnt !== 4'(1 << i)) begin
                n_err++;
                $display("FAIL rr_grant%0d: gnt=%b (seen=%0d), want %b", i, gnt, ok, 4'(1 << i));
            end
            req[i] = 1'b0;
            wait_rsp(ok);
            n_cmp++;
            if (!ok || rsp_id !== 2'(i) || rsp_data !== 32'(4*i+4)) begin
                n_err++;
                $display("FAIL rr_rsp%0d: vld_seen=%0d id=%0d data=%0d, want id %0d data %0d",
                         i, ok, rsp_id, rsp_data, i, 4*i+4);
            end
        end
    endtask

    task automatic test_negative();
        bit ok;
        win_data[256 +: 128] = win4(-8, -8, -8, -8);
        rsp_ready = 1'b1;
        tick();
        req = 4'b0100;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL neg_grant: gnt=%b (seen=%0d), want 0100", gnt, ok);
        end
        req = 4'b0000;
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd2 || rsp_data !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL neg_rsp: vld_seen=%0d id=%0d data=%h, want 2 fffffff8", ok, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        win_data[0   +: 128] = win4(4, 4, 4, 4);
        win_data[128 +: 128] = win4(8, 8, 8, 8);
        rsp_ready = 1'b0;
        req = 4'b0001;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_grant0: gnt=%b (seen=%0d), want 0001", gnt, ok);
        end
        req = 4'b0010;
        wait_rsp(ok);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (!ok || rsp_valid !== 1'b1 || rsp_data !== 32'd4 || rsp_id !== 2'd0 || gnt !== 4'b0000 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: vld=%b id=%0d data=%0d gnt=%b busy=%b, want 1 0 4 0000 1",
                         i, rsp_valid, rsp_id, rsp_data, gnt, busy);
            end
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle_gap: vld=%b gnt=%b busy=%b, want 0 0000 0", rsp_valid, gnt, busy);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_next_grant: gnt=%b, want 0010", gnt);
        end
        req = 4'b0000;
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd1 || rsp_data !== 32'd8) begin
            n_err++;
            $display("FAIL bp_rsp1: vld_seen=%0d id=%0d data=%0d, want 1 8", ok, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit leak;
        win_data[0   +: 128] = win4(1, 1, 1, 1);
        win_data[384 +: 128] = win4(12, 12, 12, 12);
        rsp_ready = 1'b1;
        req = 4'b0001;
        wait_gnt(ok);
        req = 4'b0000;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (!ok || {gnt, busy, pool_ip, pool_en, pool_rst, rsp_valid, rsp_id, rsp_data} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: gnt_seen=%0d busy=%b ip=%0d en=%b vld=%b data=%h, want all 0",
                     ok, busy, pool_ip, pool_en, rsp_valid, rsp_data);
        end
        tick();
        rst = 1'b0;
        leak = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) leak = 1'b1;
        end
        n_cmp++;
        if (leak) begin
            n_err++;
            $display("FAIL midrst_silent: vld/gnt/busy activity seen=%0d, want 0", leak);
        end
        req = 4'b1000;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_grant3: gnt=%b (seen=%0d), want 1000", gnt, ok);
        end
        req = 4'b0000;
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd3 || rsp_data !== 32'd12) begin
            n_err++;
            $display("FAIL midrst_rsp: vld_seen=%0d id=%0d data=%0d, want 3 12", ok, rsp_id, rsp_data);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        win_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_negative();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
